// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Requester, ALU and response bundle for the shared-ALU arbiter.
// Revision    : 1.0
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic [OPW-1:0]   req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [OPW-1:0]   alu_s;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_cin, alu_s,
        input  alu_out, alu_cout,
        output rsp_valid, rsp_id, rsp_result, rsp_cout,
        input  rsp_ready
    );

    // Requester / ALU / consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_cin, alu_s,
        output alu_out, alu_cout,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU by two requesters,
//               with registered operands and a tagged valid/ready response.
// Revision    : 1.0
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [WIDTH-1:0] alu_b_q,      alu_b_d;
    logic             alu_cin_q,    alu_cin_d;
    logic [OPW-1:0]   alu_s_q,      alu_s_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_cout_q,   rsp_cout_d;

    logic grant;
    logic ready0;
    logic ready1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_s_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cin_q    <= alu_cin_d;
            alu_s_q      <= alu_s_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cin_d    = alu_cin_q;
        alu_s_d      = alu_s_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;

        // A lone requester wins outright; a tie goes to whoever did not win last.
        grant  = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
        ready0 = rst_n && (state_q == S_IDLE) && !grant && bus.req0_valid;
        ready1 = rst_n && (state_q == S_IDLE) &&  grant && bus.req1_valid;

        case (state_q)
            S_IDLE: begin
                if (ready0 || ready1) begin
                    state_d      = S_ISSUE;
                    last_grant_d = grant;
                    alu_a_d      = grant ? bus.req1_a   : bus.req0_a;
                    alu_b_d      = grant ? bus.req1_b   : bus.req0_b;
                    alu_cin_d    = grant ? bus.req1_cin : bus.req0_cin;
                    alu_s_d      = grant ? bus.req1_op  : bus.req0_op;
                end
            end
            S_ISSUE: begin
                // last_grant_q already names the requester that owns this operation.
                state_d      = S_HOLD;
                rsp_valid_d  = 1'b1;
                rsp_id_d     = last_grant_q;
                rsp_result_d = bus.alu_out;
                rsp_cout_d   = bus.alu_cout;
            end
            S_HOLD: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_cin    = alu_cin_q;
    assign bus.alu_s      = alu_s_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_cout   = rsp_cout_q;

endmodule
`default_nettype wire
